cska_checker: RTL and testbench

Response-checking end of the carry-skip adder verification path. Accepts a stream of applied operand vectors together with the `cska_top` outputs they produced, computes the golden `{Cout,Sum}` from `A+B+Cin`, and keeps pass/fail/overflow counters plus a first-failure snapshot. Runs of a programmed vector count are armed with a `start` pulse. Sits beside the `cska_top` instance, downstream of the stimulus source, and is usable in simulation or on silicon as a built-in self-check.

---
 rtl/cska_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_cska_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cska_checker.sv
// cska_checker -- response checker for a carry-skip adder under test.
//
// Takes the operand vectors applied to the adder together with the {Cout,Sum}
// it produced, recomputes the golden A+B+Cin at full N+1 width and keeps
// saturating pass/fail counters, a sticky overflow flag and a snapshot of the
// first failing vector. A run of num_vectors samples is armed by start.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, num_vectors  arm a run (num_vectors sampled only with start)
//   in_valid/in_ready   sample handshake
//   in_a, in_b, in_cin  operands applied to the adder
//   in_sum, in_cout     adder response
//   busy, done, pass    run status
//   err_pulse           one-cycle pulse per mismatching vector
//   pass_cnt, fail_cnt  saturating result counters
//   overflow            sticky: sample offered while not ready in RUN/DONE
//   ff_*                first-failure snapshot (index, operands, exp/got)
//
// Pipeline: accept in cycle t -> stage 1 in t+1 (compare) -> results, err_pulse
// and the RUN->DONE transition all visible in t+2.
module cska_checker #(
  parameter int N          = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_cin,
  input  logic [N-1:0]     in_sum,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             overflow,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_idx,
  output logic [N-1:0]     ff_a,
  output logic [N-1:0]     ff_b,
  output logic             ff_cin,
  output logic [N:0]       ff_exp,
  output logic [N:0]       ff_got
);

  // BLOCK_SIZE only describes the adder being checked; reject nonsense values.
  if (BLOCK_SIZE < 1 || BLOCK_SIZE > N) begin : g_bad_block_size
    $error("cska_checker: BLOCK_SIZE must be in 1..N");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] nv_q, nv_d;

  // stage 1 (compare stage)
  logic             s1_vld_q, s1_vld_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  logic [N:0]       s1_got_q, s1_got_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

  // results
  logic             err_q, err_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             ovf_q, ovf_d;
  logic             ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [N-1:0]     ff_a_q, ff_a_d;
  logic [N-1:0]     ff_b_q, ff_b_d;
  logic             ff_cin_q, ff_cin_d;
  logic [N:0]       ff_exp_q, ff_exp_d;
  logic [N:0]       ff_got_q, ff_got_d;

  logic             accept;
  logic [N:0]       s1_exp;
  logic             s1_mismatch;

  // start blocks acceptance in its own cycle so a restart never counts a sample
  assign in_ready    = (state_q == S_RUN) && (remaining_q != '0) && !start;
  assign accept      = in_valid && in_ready;

  // golden sum at full N+1 width so the carry-out is never truncated
  assign s1_exp      = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{N{1'b0}}, s1_cin_q};
  assign s1_mismatch = (s1_exp != s1_got_q);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    nv_d        = nv_q;
    s1_vld_d    = 1'b0;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_cin_d    = s1_cin_q;
    s1_got_d    = s1_got_q;
    s1_idx_d    = s1_idx_q;
    err_d       = 1'b0;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    ovf_d       = ovf_q;
    ff_valid_d  = ff_valid_q;
    ff_idx_d    = ff_idx_q;
    ff_a_d      = ff_a_q;
    ff_b_d      = ff_b_q;
    ff_cin_d    = ff_cin_q;
    ff_exp_d    = ff_exp_q;
    ff_got_d    = ff_got_q;

    if (start) begin
      // restart from any state: reload everything, flush stage 1
      state_d     = (num_vectors == '0) ? S_DONE : S_RUN;
      remaining_d = num_vectors;
      nv_d        = num_vectors;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      ovf_d       = 1'b0;
      ff_valid_d  = 1'b0;
      ff_idx_d    = '0;
      ff_a_d      = '0;
      ff_b_d      = '0;
      ff_cin_d    = 1'b0;
      ff_exp_d    = '0;
      ff_got_d    = '0;
    end else begin
      if (accept) begin
        s1_vld_d    = 1'b1;
        s1_a_d      = in_a;
        s1_b_d      = in_b;
        s1_cin_d    = in_cin;
        s1_got_d    = {in_cout, in_sum};
        s1_idx_d    = nv_q - remaining_q;
        remaining_d = remaining_q - 1'b1;
      end else if (in_valid && state_q != S_IDLE) begin
        ovf_d = 1'b1;
      end

      if (s1_vld_q) begin
        if (s1_mismatch) begin
          err_d = 1'b1;
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = s1_idx_q;
            ff_a_d     = s1_a_q;
            ff_b_d     = s1_b_q;
            ff_cin_d   = s1_cin_q;
            ff_exp_d   = s1_exp;
            ff_got_d   = s1_got_q;
          end
        end else if (pass_cnt_q != '1) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
        end
      end

      // with remaining at zero nothing new can enter, so stage 1 holds the last
      if (state_q == S_RUN && s1_vld_q && remaining_q == '0) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      nv_q        <= '0;
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_got_q    <= '0;
      s1_idx_q    <= '0;
      err_q       <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      ff_valid_q  <= 1'b0;
      ff_idx_q    <= '0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_cin_q    <= 1'b0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      nv_q        <= nv_d;
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_got_q    <= s1_got_d;
      s1_idx_q    <= s1_idx_d;
      err_q       <= err_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      ovf_q       <= ovf_d;
      ff_valid_q  <= ff_valid_d;
      ff_idx_q    <= ff_idx_d;
      ff_a_q      <= ff_a_d;
      ff_b_q      <= ff_b_d;
      ff_cin_q    <= ff_cin_d;
      ff_exp_q    <= ff_exp_d;
      ff_got_q    <= ff_got_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (fail_cnt_q == '0) && !ovf_q;
  assign err_pulse = err_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign overflow  = ovf_q;
  assign ff_valid  = ff_valid_q;
  assign ff_idx    = ff_idx_q;
  assign ff_a      = ff_a_q;
  assign ff_b      = ff_b_q;
  assign ff_cin    = ff_cin_q;
  assign ff_exp    = ff_exp_q;
  assign ff_got    = ff_got_q;

endmodule

// File: tb/tb_cska_checker.sv
// Bench for cska_checker: directed scenarios plus randomized runs, checked every
// cycle against a transaction-level model (accepted vectors queued with the
// edge at which their result must become visible).
module tb_cska_checker;
  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0, in_b = '0, in_sum = '0;
  logic             in_cin = 1'b0, in_cout = 1'b0;
  logic             busy, done, pass, err_pulse, overflow, ff_valid, ff_cin;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, ff_idx;
  logic [N-1:0]     ff_a, ff_b;
  logic [N:0]       ff_exp, ff_got;

  cska_checker #(.N(N), .BLOCK_SIZE(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout), .busy(busy),
    .done(done), .pass(pass), .err_pulse(err_pulse), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .overflow(overflow), .ff_valid(ff_valid),
    .ff_idx(ff_idx), .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin),
    .ff_exp(ff_exp), .ff_got(ff_got)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int a; int b; int cin; int got; int idx; int due;} item_t;
  item_t q[$];
  int m_mode = 0;   // 0 idle, 1 run, 2 done
  int m_rem = 0, m_nv = 0, m_pass = 0, m_fail = 0, edge_n = 0;
  bit m_ovf = 0, m_errp = 0, m_ffv = 0;
  int m_ffidx = 0, m_ffa = 0, m_ffb = 0, m_ffcin = 0, m_ffexp = 0, m_ffgot = 0;

  task automatic m_clear();
    m_pass = 0; m_fail = 0; m_ovf = 0; m_errp = 0; m_ffv = 0;
    m_ffidx = 0; m_ffa = 0; m_ffb = 0; m_ffcin = 0; m_ffexp = 0; m_ffgot = 0;
    q.delete();
  endtask

  always @(posedge clk) begin
    bit rdy;
    item_t it;
    int e;
    edge_n++;
    rdy = (m_mode == 1) && (m_rem != 0) && !start;
    if (rst) begin
      m_mode = 0; m_rem = 0; m_nv = 0; m_clear();
    end else if (start) begin
      m_mode = (num_vectors == 0) ? 2 : 1;
      m_rem = int'(num_vectors); m_nv = int'(num_vectors); m_clear();
    end else begin
      m_errp = 0;
      while (q.size() > 0 && q[0].due == edge_n) begin
        it = q.pop_front();
        e = it.a + it.b + it.cin;
        if (e != it.got) begin
          m_errp = 1;
          if (m_fail < MAXC) m_fail++;
          if (!m_ffv) begin
            m_ffv = 1; m_ffidx = it.idx; m_ffa = it.a; m_ffb = it.b;
            m_ffcin = it.cin; m_ffexp = e; m_ffgot = it.got;
          end
        end else if (m_pass < MAXC) m_pass++;
      end
      if (in_valid && rdy) begin
        it.a = int'(in_a); it.b = int'(in_b); it.cin = int'(in_cin);
        it.got = int'(in_cout) * (1 << N) + int'(in_sum);
        it.idx = m_nv - m_rem; it.due = edge_n + 1;
        q.push_back(it);
        m_rem--;
      end else if (in_valid && m_mode != 0) m_ovf = 1;
      if (m_mode == 1 && m_rem == 0 && q.size() == 0) m_mode = 2;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  (m_mode == 1 && m_rem != 0 && !start));
      chk("busy",      busy,      (m_mode == 1));
      chk("done",      done,      (m_mode == 2));
      chk("pass",      pass,      (m_mode == 2 && m_fail == 0 && !m_ovf));
      chk("err_pulse", err_pulse, m_errp);
      chk("pass_cnt",  pass_cnt,  m_pass);
      chk("fail_cnt",  fail_cnt,  m_fail);
      chk("overflow",  overflow,  m_ovf);
      chk("ff_valid",  ff_valid,  m_ffv);
      chk("ff_idx",    ff_idx,    m_ffidx);
      chk("ff_a",      ff_a,      m_ffa);
      chk("ff_b",      ff_b,      m_ffb);
      chk("ff_cin",    ff_cin,    m_ffcin);
      chk("ff_exp",    ff_exp,    m_ffexp);
      chk("ff_got",    ff_got,    m_ffgot);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit st, input int nv, input bit v,
                      input int a, input int b, input int cin, input int got);
    logic [31:0] ga, gb, gc, gg, gn;
    @(negedge clk); #1;
    ga = a; gb = b; gc = cin; gg = got; gn = nv;
    rst = r; start = st; num_vectors = gn[CNT_W-1:0]; in_valid = v;
    in_a = ga[N-1:0]; in_b = gb[N-1:0]; in_cin = gc[0];
    in_sum = gg[N-1:0]; in_cout = gg[N];
  endtask

  task automatic idle();                 step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic kick(input int nv);     step(0, 1, nv, 0, 0, 0, 0, 0); endtask
  task automatic vec(input int a, input int b, input int cin, input int got);
    step(0, 0, 0, 1, a, b, cin, got);
  endtask
  task automatic good(input int a, input int b, input int cin);
    vec(a, b, cin, a + b + cin);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset pass_cnt", pass_cnt, 0);
    chk("reset ff_got", ff_got, 0);

    // single all-zero vector
    kick(1); good(0, 0, 0); idle(); idle();
    chk("t1 done", done, 1); chk("t1 pass", pass, 1); chk("t1 pass_cnt", pass_cnt, 1);

    // carry-out cases
    kick(2); vec(15, 15, 0, 5'h1E); vec(15, 1, 0, 5'h10); idle(); idle();
    chk("t2 pass_cnt", pass_cnt, 2); chk("t2 fail_cnt", fail_cnt, 0); chk("t2 pass", pass, 1);

    // corrupted second vector
    kick(3); good(2, 7, 0); vec(5, 3, 1, 5'h08); good(9, 9, 1); idle(); idle();
    chk("t3 fail_cnt", fail_cnt, 1); chk("t3 pass", pass, 0);
    chk("t3 ff_idx", ff_idx, 1); chk("t3 ff_exp", ff_exp, 5'h09); chk("t3 ff_got", ff_got, 5'h08);

    // overflow: three samples into a two-vector run
    kick(2); good(1, 2, 0); good(1, 2, 0); good(1, 2, 0); idle(); idle();
    chk("t4 overflow", overflow, 1); chk("t4 pass", pass, 0);
    chk("t4 total", pass_cnt + fail_cnt, 2);

    // empty run
    kick(0); idle();
    chk("t5 done", done, 1); chk("t5 pass", pass, 1); chk("t5 in_ready", in_ready, 0);

    // restart with a vector in stage 1, then reset with a vector in stage 1
    kick(3); good(3, 4, 0); kick(3); idle(); idle();
    chk("t6 pass_cnt", pass_cnt, 0); chk("t6 busy", busy, 1);
    good(1, 1, 0); step(1, 0, 0, 0, 0, 0, 0, 0); idle();
    chk("t6 rst busy", busy, 0); chk("t6 rst pass_cnt", pass_cnt, 0);
    chk("t6 rst in_ready", in_ready, 0);

    // randomized runs
    for (int r = 0; r < 60; r++) begin
      int nv;
      nv = $urandom_range(0, 7);
      kick(nv);
      for (int c = 0; c < nv + 5; c++) begin
        int a, b, ci, g, sel;
        a = $urandom_range(0, 15); b = $urandom_range(0, 15); ci = $urandom_range(0, 1);
        g = a + b + ci;
        if ($urandom_range(0, 3) == 0) g = g ^ $urandom_range(1, 31);
        sel = $urandom_range(0, 99);
        if (sel < 2)      step(0, 1, $urandom_range(0, 5), 0, 0, 0, 0, 0);
        else if (sel < 3) step(1, 0, 0, 0, 0, 0, 0, 0);
        else              step(0, 0, 0, (sel < 75), a, b, ci, g);
      end
      idle(); idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
